// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared constants, FSM state type and PRBS7 parameters
package serializer_pkg;

  localparam logic [9:0] TMDS_CTRL_00  = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01  = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10  = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11  = 10'b1010101011;
  localparam logic [9:0] CLOCK_WORD_10 = 10'b0000011111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // x^7 + x^6 + 1: feedback is lfsr[6] ^ lfsr[5]
  localparam logic [6:0] PRBS7_TAPS = 7'b1100000;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

endpackage

// File: rtl/serializer_word_fifo.sv
// rtl/serializer_word_fifo.sv - show-ahead synchronous word FIFO with occupancy output
module serializer_word_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [LVL_W-1:0] o_level,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/serializer_stream.sv
// rtl/serializer_stream.sv - multi-lane word serializer with clock lane, FIFO priming and drain
// Optional PRBS7 test pattern source enabled by SERIALIZER_STREAM_PRBS_EN.
module serializer_stream
  import serializer_pkg::*;
#(
  parameter int                    NUM_CHANNELS = 3,
  parameter int                    WORD_WIDTH   = 10,
  parameter int                    BITS_PER_CLK = 2,
  parameter int                    FIFO_DEPTH   = 4,
  parameter int                    PRIME_LEVEL  = 2,
  parameter logic [WORD_WIDTH-1:0] IDLE_WORD    = TMDS_CTRL_00,
  parameter logic [WORD_WIDTH-1:0] CLOCK_WORD   = CLOCK_WORD_10,
  localparam int                   LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    i_clk_pixel_x5,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
`ifdef SERIALIZER_STREAM_PRBS_EN
  input  logic                    i_prbs_mode,
`endif
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [WORD_WIDTH-1:0]   i_in_data [NUM_CHANNELS-1:0],
  output logic [BITS_PER_CLK-1:0] o_out_bits [NUM_CHANNELS-1:0],
  output logic [BITS_PER_CLK-1:0] o_out_clock,
  output logic                    o_word_start,
  output logic                    o_underflow,
  output logic [LVL_W-1:0]        o_fifo_level
);

  localparam int SLOTS  = WORD_WIDTH / BITS_PER_CLK;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int FLAT_W = NUM_CHANNELS * WORD_WIDTH;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [LVL_W-1:0]  PRIME_LVL = LVL_W'(PRIME_LEVEL);

  if (WORD_WIDTH % BITS_PER_CLK != 0) begin : g_bad_bits
    $error("BITS_PER_CLK must divide WORD_WIDTH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if ((PRIME_LEVEL < 1) || (PRIME_LEVEL > FIFO_DEPTH)) begin : g_bad_prime
    $error("PRIME_LEVEL must be in 1..FIFO_DEPTH");
  end

  state_t                  r_state;
  state_t                  w_state_next;
  logic [WORD_WIDTH-1:0]   r_shift [NUM_CHANNELS];
  logic [WORD_WIDTH-1:0]   r_clk_shift;
  logic [SLOT_W-1:0]       r_slot;
  logic                    r_word_start;
  logic                    r_underflow;

  logic                    w_load;
  logic                    w_prbs;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_underflow_load;
  logic                    w_full;
  logic                    w_empty;
  logic [LVL_W-1:0]        w_level;
  logic [FLAT_W-1:0]       w_fifo_wdata;
  logic [FLAT_W-1:0]       w_fifo_rdata;
  logic [WORD_WIDTH-1:0]   w_load_word [NUM_CHANNELS];

  always_comb begin
    w_fifo_wdata = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      w_fifo_wdata[ch*WORD_WIDTH +: WORD_WIDTH] = i_in_data[ch];
    end
  end

  assign o_in_ready = !w_full;
  assign w_push     = i_in_valid && o_in_ready;

  serializer_word_fifo #(
    .WIDTH (FLAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk_pixel_x5),
    .i_rst_n (i_reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_fifo_wdata),
    .o_rdata (w_fifo_rdata),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef SERIALIZER_STREAM_PRBS_EN
  logic [6:0]            r_lfsr;
  logic [6:0]            w_lfsr_adv;
  logic [WORD_WIDTH-1:0] w_prbs_word;

  assign w_prbs = i_prbs_mode;

  // One load consumes WORD_WIDTH successive generator bits, first bit in slot 0.
  always_comb begin
    w_lfsr_adv  = r_lfsr;
    w_prbs_word = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      w_prbs_word[i] = ^(w_lfsr_adv & PRBS7_TAPS);
      w_lfsr_adv     = {w_lfsr_adv[5:0], w_prbs_word[i]};
    end
  end

  always_ff @(posedge i_clk_pixel_x5 or negedge i_reset_n) begin
    if (!i_reset_n)           r_lfsr <= PRBS7_SEED;
    else if (w_load && w_prbs) r_lfsr <= w_lfsr_adv;
  end
`else
  assign w_prbs = 1'b0;
`endif

  assign w_pop            = w_load && !w_prbs && !w_empty;
  assign w_underflow_load = w_load && !w_prbs && w_empty;

  always_comb begin
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      w_load_word[ch] = w_fifo_rdata[ch*WORD_WIDTH +: WORD_WIDTH];
      if (w_empty) w_load_word[ch] = IDLE_WORD;
`ifdef SERIALIZER_STREAM_PRBS_EN
      if (w_prbs) w_load_word[ch] = w_prbs_word;
`endif
    end
  end

  always_ff @(posedge i_clk_pixel_x5 or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_enable) w_state_next = ST_PRIME;
      end
      ST_PRIME: begin
        if (!i_enable) begin
          w_state_next = ST_IDLE;
        end else if (w_level >= PRIME_LVL) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Enable is only honoured at a word boundary so words are never cut short.
        if (r_slot == SLOT_LAST) begin
          if (i_enable) w_load       = 1'b1;
          else          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Zero-filled right shifts leave the lanes at 0 once the last slot has gone out.
  always_ff @(posedge i_clk_pixel_x5 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) r_shift[ch] <= '0;
      r_clk_shift  <= '0;
      r_slot       <= '0;
      r_word_start <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_word_start <= w_load;
      if (w_underflow_load) r_underflow <= 1'b1;
      if (w_load) begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) r_shift[ch] <= w_load_word[ch];
        r_clk_shift <= CLOCK_WORD;
        r_slot      <= '0;
      end else begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) r_shift[ch] <= r_shift[ch] >> BITS_PER_CLK;
        r_clk_shift <= r_clk_shift >> BITS_PER_CLK;
        if (r_state == ST_RUN) r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      o_out_bits[ch] = r_shift[ch][BITS_PER_CLK-1:0];
    end
  end

  assign o_out_clock  = r_clk_shift[BITS_PER_CLK-1:0];
  assign o_word_start = r_word_start;
  assign o_underflow  = r_underflow;
  assign o_fifo_level = w_level;

endmodule

// File: tb/tb_serializer_stream.sv
// tb/tb_serializer_stream.sv - directed self-checking bench for serializer_stream
module tb_serializer_stream;

  localparam logic [9:0]  IDLE_W = 10'b1101010100;
  // packed word sets: {ch2, ch1, ch0}
  localparam logic [29:0] WA  = {10'h0F0, 10'h1A5, 10'h2D3};
  localparam logic [29:0] WB  = {10'h27E, 10'h3C3, 10'h155};
  localparam logic [29:0] WC  = {10'h0CC, 10'h333, 10'h2AA};
  localparam logic [29:0] PAT = {10'h155, 10'h000, 10'h3FF};
  localparam logic [29:0] IDLE3 = {IDLE_W, IDLE_W, IDLE_W};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] in_data [2:0];
  logic [1:0] out_bits [2:0];
  logic [1:0] out_clock;
  logic       word_start;
  logic       underflow;
  logic [2:0] fifo_level;
`ifdef SERIALIZER_STREAM_PRBS_EN
  logic       prbs_mode = 1'b0;
`endif

  logic [1:0] clk_exp [5];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serializer_stream dut (
    .i_clk_pixel_x5 (clk),
    .i_reset_n      (rst_n),
    .i_enable       (enable),
`ifdef SERIALIZER_STREAM_PRBS_EN
    .i_prbs_mode    (prbs_mode),
`endif
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_data      (in_data),
    .o_out_bits     (out_bits),
    .o_out_clock    (out_clock),
    .o_word_start   (word_start),
    .o_underflow    (underflow),
    .o_fifo_level   (fifo_level)
  );

  task automatic set_data(input logic [29:0] ws);
    for (int ch = 0; ch < 3; ch++) in_data[ch] = ws[ch*10 +: 10];
  endtask

  // Leaves the caller just after the negedge on which reset is released.
  task automatic do_reset(input logic en);
    @(negedge clk);
    rst_n = 1'b0; enable = en; in_valid = 1'b0; set_data('0);
`ifdef SERIALIZER_STREAM_PRBS_EN
    prbs_mode = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; set_data('0);
    @(negedge clk);
    for (int ch = 0; ch < 3; ch++) begin
      checks++;
      if (out_bits[ch] !== 2'b00) begin errors++; $display("FAIL reset_out_bits ch%0d got %b exp 00", ch, out_bits[ch]); end
    end
    checks++; if (out_clock !== 2'b00) begin errors++; $display("FAIL reset_out_clock got %b exp 00", out_clock); end
    checks++; if (word_start !== 1'b0) begin errors++; $display("FAIL reset_word_start got %b exp 0", word_start); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", underflow); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_fifo_level got %0d exp 0", fifo_level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_first_word();
    logic [29:0] w;
    int s;
    do_reset(1'b1);
    in_valid = 1'b1; set_data(WA);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) set_data(WB);
      if (c == 2) in_valid = 1'b0;
      checks++;
      if (fifo_level !== ((c == 1) ? 3'd1 : (c == 2) ? 3'd2 : (c < 8) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL first_level c%0d got %0d", c, fifo_level);
      end
      if (c < 3) begin
        checks++;
        if (word_start !== 1'b0 || out_clock !== 2'b00) begin
          errors++; $display("FAIL first_prime_idle c%0d got ws=%b clk=%b exp ws=0 clk=00", c, word_start, out_clock);
        end
      end else begin
        s = (c - 3) % 5;
        w = (c < 8) ? WA : WB;
        for (int ch = 0; ch < 3; ch++) begin
          checks++;
          if (out_bits[ch] !== w[ch*10 + 2*s +: 2]) begin
            errors++; $display("FAIL first_bits c%0d ch%0d got %b exp %b", c, ch, out_bits[ch], w[ch*10 + 2*s +: 2]);
          end
        end
        checks++;
        if (out_clock !== clk_exp[s]) begin errors++; $display("FAIL first_clock c%0d got %b exp %b", c, out_clock, clk_exp[s]); end
        checks++;
        if (word_start !== (s == 0)) begin errors++; $display("FAIL first_word_start c%0d got %b exp %b", c, word_start, (s == 0)); end
      end
    end
  endtask

  task automatic test_continuous();
    int s;
    do_reset(1'b1);
    in_valid = 1'b1; set_data(PAT);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      in_valid = ((c + 1) <= 3) || (((c + 1) % 5 == 3) && ((c + 1) <= 23));
      if (c >= 3) begin
        s = (c - 3) % 5;
        for (int ch = 0; ch < 3; ch++) begin
          checks++;
          if (out_bits[ch] !== PAT[ch*10 + 2*s +: 2]) begin
            errors++; $display("FAIL cont_bits c%0d ch%0d got %b exp %b", c, ch, out_bits[ch], PAT[ch*10 + 2*s +: 2]);
          end
        end
        checks++;
        if (out_clock !== clk_exp[s]) begin errors++; $display("FAIL cont_clock c%0d got %b exp %b", c, out_clock, clk_exp[s]); end
        checks++;
        if (fifo_level !== 3'd2) begin errors++; $display("FAIL cont_level c%0d got %0d exp 2", c, fifo_level); end
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL cont_underflow c%0d got %b exp 0", c, underflow); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_underflow();
    logic [29:0] w;
    int s;
    do_reset(1'b1);
    in_valid = 1'b1; set_data(WA);
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      if (c == 1) set_data(WB);
      if (c == 2) set_data(WC);
      if (c == 3) in_valid = 1'b0;
      if (c >= 3) begin
        s = (c - 3) % 5;
        w = ((c - 3) / 5 == 0) ? WA : ((c - 3) / 5 == 1) ? WB : ((c - 3) / 5 == 2) ? WC : IDLE3;
        for (int ch = 0; ch < 3; ch++) begin
          checks++;
          if (out_bits[ch] !== w[ch*10 + 2*s +: 2]) begin
            errors++; $display("FAIL uflow_bits c%0d ch%0d got %b exp %b", c, ch, out_bits[ch], w[ch*10 + 2*s +: 2]);
          end
        end
        checks++;
        if (underflow !== (c >= 18)) begin errors++; $display("FAIL uflow_flag c%0d got %b exp %b", c, underflow, (c >= 18)); end
      end
    end
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL uflow_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_full();
    logic [29:0] ys [5];
    logic [29:0] w;
    int s;
    ys[0] = {10'h001, 10'h002, 10'h004};
    ys[1] = {10'h208, 10'h110, 10'h0A0};
    ys[2] = {10'h3E1, 10'h01F, 10'h2B6};
    ys[3] = {10'h049, 10'h392, 10'h15C};
    ys[4] = {10'h2F0, 10'h10F, 10'h3A5};
    do_reset(1'b0);
    in_valid = 1'b1; set_data(ys[0]);
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      if (c <= 4) set_data(ys[c]);
      if (c == 5) enable = 1'b1;
      if (c >= 4 && c <= 8) begin
        checks++;
        if (fifo_level !== ((c == 7) ? 3'd3 : 3'd4)) begin
          errors++; $display("FAIL full_level c%0d got %0d exp %0d", c, fifo_level, (c == 7) ? 3 : 4);
        end
        checks++;
        if (in_ready !== (c == 7)) begin errors++; $display("FAIL full_in_ready c%0d got %b exp %b", c, in_ready, (c == 7)); end
      end
      if (c == 8) in_valid = 1'b0;
      if (c >= 7) begin
        s = (c - 7) % 5;
        w = ys[(c - 7) / 5];
        for (int ch = 0; ch < 3; ch++) begin
          checks++;
          if (out_bits[ch] !== w[ch*10 + 2*s +: 2]) begin
            errors++; $display("FAIL full_bits c%0d ch%0d got %b exp %b", c, ch, out_bits[ch], w[ch*10 + 2*s +: 2]);
          end
        end
        checks++;
        if (word_start !== (s == 0)) begin errors++; $display("FAIL full_word_start c%0d got %b exp %b", c, word_start, (s == 0)); end
      end
    end
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL full_underflow got %b exp 0", underflow); end
  endtask

  task automatic test_drain();
    logic [29:0] w;
    int s;
    do_reset(1'b1);
    in_valid = 1'b1; set_data(WC);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) set_data(WA);
      if (c == 2) set_data(WB);
      if (c == 3) in_valid = 1'b0;
      if ((c >= 3 && c <= 7) || c >= 12) begin
        s = (c >= 12) ? (c - 12) : (c - 3);
        w = (c >= 12) ? WA : WC;
        for (int ch = 0; ch < 3; ch++) begin
          checks++;
          if (out_bits[ch] !== w[ch*10 + 2*s +: 2]) begin
            errors++; $display("FAIL drain_bits c%0d ch%0d got %b exp %b", c, ch, out_bits[ch], w[ch*10 + 2*s +: 2]);
          end
        end
        checks++;
        if (word_start !== (s == 0)) begin errors++; $display("FAIL drain_word_start c%0d got %b exp %b", c, word_start, (s == 0)); end
      end else if (c >= 8) begin
        checks++;
        if (out_bits[0] !== 2'b00 || out_bits[1] !== 2'b00 || out_bits[2] !== 2'b00 || out_clock !== 2'b00 || word_start !== 1'b0) begin
          errors++; $display("FAIL drain_quiet c%0d got %b %b %b clk=%b ws=%b exp all 0", c, out_bits[0], out_bits[1], out_bits[2], out_clock, word_start);
        end
        checks++;
        if (fifo_level !== 3'd2) begin errors++; $display("FAIL drain_level c%0d got %0d exp 2", c, fifo_level); end
      end
      if (c == 4)  enable = 1'b0;
      if (c == 10) enable = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    in_valid = 1'b1; set_data(WB);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) set_data(WA);
      if (c == 2) in_valid = 1'b0;
    end
    checks++;
    if (out_bits[0] !== WB[7:6]) begin errors++; $display("FAIL midrst_pre got %b exp %b", out_bits[0], WB[7:6]); end
    #1 rst_n = 1'b0;
    #1;
    for (int ch = 0; ch < 3; ch++) begin
      checks++;
      if (out_bits[ch] !== 2'b00) begin errors++; $display("FAIL midrst_bits ch%0d got %b exp 00", ch, out_bits[ch]); end
    end
    checks++; if (out_clock !== 2'b00) begin errors++; $display("FAIL midrst_clock got %b exp 00", out_clock); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL midrst_level got %0d exp 0", fifo_level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef SERIALIZER_STREAM_PRBS_EN
  task automatic test_prbs();
    logic [9:0] pw;
    int s;
    pw = 10'h040;
    do_reset(1'b1);
    prbs_mode = 1'b1;
    in_valid = 1'b1; set_data(WA);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) set_data(WB);
      if (c == 2) in_valid = 1'b0;
      if (c >= 3) begin
        s = c - 3;
        checks++;
        if (out_bits[0] !== pw[2*s +: 2]) begin errors++; $display("FAIL prbs_bits c%0d got %b exp %b", c, out_bits[0], pw[2*s +: 2]); end
        checks++;
        if (fifo_level !== 3'd2) begin errors++; $display("FAIL prbs_level c%0d got %0d exp 2", c, fifo_level); end
      end
    end
    prbs_mode = 1'b0;
  endtask
`endif

  initial begin
    clk_exp[0] = 2'b11; clk_exp[1] = 2'b11; clk_exp[2] = 2'b01; clk_exp[3] = 2'b00; clk_exp[4] = 2'b00;
    set_data('0);
    test_reset();
    test_first_word();
    test_continuous();
    test_underflow();
    test_full();
    test_drain();
    test_reset_mid();
`ifdef SERIALIZER_STREAM_PRBS_EN
    test_prbs();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
